axi_aw_arbiter: RTL and testbench
=================================

// Module: axi_aw_arbiter
// PURPOSE
//  Shares one AXI write-address (AW) channel between NUM_REQ requesters using round-robin arbitration.
//  Tags each awid with the requester index in its upper bits so write responses route back to the source.
//  Limits write transactions in flight per requester; each write is counted from AW acceptance to B handshake.
//  Sits between the CNN write-DMA engines and the AW master side of the AXI write-address channel.
// PARAMETERS
//  NUM_REQ          4        number of requesters (>=2)
//  ID_MAX_WIDTH     16       AXI awid/bid width
//  ADDR_WIDTH       32       AXI address width
//  MAX_OUTSTANDING  8        max write transactions in flight per requester (1..255)
//  AWCACHE_VAL      4'b0011  constant driven on m_awcache
//  IDX_W            localparam $clog2(NUM_REQ); LID_W = ID_MAX_WIDTH-IDX_W
// PORTS
//  clk            in   1                clock
//  rst            in   1                synchronous reset, active-high
//  req_valid      in   NUM_REQ          requester r has an AW request
//  req_ready      out  NUM_REQ          one-hot accept; request taken when valid&ready
//  req_id         in   NUM_REQ*LID_W    requester-local transaction id
//  req_addr       in   NUM_REQ*ADDR_WIDTH  burst start address
//  req_len        in   NUM_REQ*4        burst length-1
//  req_size       in   NUM_REQ*3        beat size
//  req_burst      in   NUM_REQ*2        burst type
//  req_prot       in   NUM_REQ*3        protection
//  req_qos        in   NUM_REQ*4        qos (passed through, not used for arbitration)
//  m_awvalid/awready/awid/awaddr/awlen/awsize/awbrust/awlock/awcache/awprot/awqos
//                 out/in/out...        AW master bus: widths 1/1/ID_MAX_WIDTH/ADDR_WIDTH/4/3/2/2/4/3/4
//  b_valid        in   1                B channel valid (snooped)
//  b_ready        in   1                B channel ready (snooped)
//  b_id           in   ID_MAX_WIDTH     B channel id; [ID_MAX_WIDTH-1 -: IDX_W] selects the source
//  outstanding    out  NUM_REQ*8        per-requester in-flight count
//  err_underflow  out  1                sticky: B handshake arrived for a requester whose count is 0
// BEHAVIOUR
//  Reset (sync, 1 cycle): all outputs = 0; counts = 0; rr pointer = NUM_REQ-1 (requester 0 has top priority).
//    An in-flight m_awvalid drops the cycle after rst and the held request is lost.
//  Eligibility: elig[r] = req_valid[r] && (outstanding[r] < MAX_OUTSTANDING).
//  FSM has two states, IDLE and HOLD. The output register is empty in IDLE and full in HOLD.
//    IDLE: if any elig, grant the first eligible requester g after the pointer (wrapping modulo NUM_REQ).
//      Assert req_ready[g] combinationally in that cycle.
//      Load the output register from g; set pointer = g; go to HOLD. Otherwise stay in IDLE.
//    HOLD: m_awvalid=1; all m_aw* fields stay stable until m_awready.
//      On m_awready with elig!=0: arbitrate as in IDLE in the same cycle and reload the register (back-to-back, no bubble).
//      On m_awready with no eligible requester: go to IDLE; m_awvalid=0 next cycle.
//      Without m_awready: req_ready=0.
//  Latency: request accepted in cycle N -> m_awvalid=1 in N+1. Throughput is 1 AW per cycle with m_awready held high.
//  m_awid = {g[IDX_W-1:0], req_id[g]}; m_awlock = 2'b00; m_awcache = AWCACHE_VAL; the other fields are copied from g.
//  At most one req_ready bit is set in any cycle.
//  Count update:
//    inc[r] on acceptance (req_valid[r]&&req_ready[r]), so budget is reserved before AW issue.
//    dec[r] on b_valid&&b_ready with source==r.
//    inc and dec in the same cycle for the same r: count unchanged.
//    dec at count 0: count stays 0 and err_underflow is set (cleared only by rst).
//    A source index >= NUM_REQ is ignored.
//  Count never exceeds MAX_OUTSTANDING; a requester at the limit is skipped and the pointer does not stall on it.
//  Requester obligation: req_* fields stay stable while req_valid is high and unaccepted. The block does not check this.
// STRUCTURE
//  axi_pkg (shared package): burst_t enum {FIXED=2'b00, INCR=2'b01, WRAP=2'b10}, AXI3 field widths,
//    AWLOCK_NORMAL constant. Reused by the W/B/AR channel blocks.
//  Sub-module axi_rr_arbiter #(N): inputs req[N], advance; outputs grant one-hot, grant_idx, any.
//    Owns the pointer register; the pointer updates only on advance.
//  Top level: FSM, output register, counter array, underflow flag.
// TESTING
//  1. Single requester: req_valid[1]=1, addr=0x1000, len=3, req_id=0x5, m_awready=1 ->
//     req_ready[1] in cycle N; m_awvalid, awaddr=0x1000, awid=0x4005 in N+1; outstanding[1]=1.
//  2. All 4 requesters valid continuously, m_awready=1 -> grants 0,1,2,3,0... with one grant per cycle and no bubble.
//  3. Backpressure: m_awready=0 for 5 cycles while m_awvalid=1 -> all m_aw* fields stable; req_ready=0 throughout.
//     Release -> next grant in the same cycle.
//  4. MAX_OUTSTANDING=2, requester 0 issues 2 with no B -> requester 0 skipped while requesters 1-3 are served.
//     b handshake with b_id=0x0xxx -> requester 0 is eligible again next cycle.
//  5. Same cycle: requester 2 accepted and b_id source=2 -> outstanding[2] unchanged.
//     B for source 3 while its count is 0 -> err_underflow=1, count stays 0.
//  6. rst asserted while m_awvalid=1 and counts nonzero -> next cycle m_awvalid=0, counts=0.
//     After release, requester 0 wins first.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the AW/W/B/AR channel blocks.
// Holds the burst-type enum, the AXI3 field widths and the normal-access lock
// encoding. There are no ports; the other files import this package.
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  localparam int AXI_LEN_W   = 4;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_LOCK_W  = 2;
  localparam int AXI_CACHE_W = 4;
  localparam int AXI_PROT_W  = 3;
  localparam int AXI_QOS_W   = 4;

  localparam logic [AXI_LOCK_W-1:0] AWLOCK_NORMAL = 2'b00;

endpackage

// File: rtl/axi_rr_arbiter.sv
// Round-robin arbiter.
// Grants the first requester after the pointer, wrapping modulo N. The pointer
// moves to the granted index only when advance is high, so a grant that is
// not taken does not rotate priority.
// Ports:
//   clk, rst   clock, synchronous active-high reset (pointer -> N-1)
//   req        N request lines
//   advance    grant is consumed this cycle; pointer takes grant_idx
//   grant      one-hot grant (zero when no request)
//   grant_idx  index of the granted requester
//   any        at least one request present
module axi_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand [N];

  // Candidate order: ptr+1, ptr+2, ..., ptr (modulo N).
  always_comb begin
    for (int i = 0; i < N; i++) begin
      cand[i] = IW'((int'(ptr) + i + 1) % N);
    end
  end

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[cand[i]]) begin
        any              = 1'b1;
        grant[cand[i]]   = 1'b1;
        grant_idx        = cand[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= IW'(N - 1);
    end else if (advance) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/axi_aw_arbiter.sv
// AXI write-address arbiter.
// Shares one AW master channel between NUM_REQ write-DMA requesters with
// round-robin priority. The requester index is placed in the top bits of
// awid so B responses can be routed back, and each requester is limited to
// MAX_OUTSTANDING writes counted from acceptance to B handshake.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    per-requester handshake (ready is one-hot)
//   req_id/addr/len/size/burst/prot/qos   packed per-requester AW fields
//   m_aw*                    AW master channel (registered outputs)
//   b_valid/b_ready/b_id     snooped B channel, releases in-flight budget
//   outstanding              packed 8-bit in-flight count per requester
//   err_underflow            sticky: B seen for a requester with count 0
//
// state  | meaning
// S_IDLE | output register empty, m_awvalid low
// S_HOLD | output register full, m_awvalid high until m_awready
module axi_aw_arbiter
  import axi_pkg::*;
#(
  parameter int          NUM_REQ         = 4,
  parameter int          ID_MAX_WIDTH    = 16,
  parameter int          ADDR_WIDTH      = 32,
  parameter int          MAX_OUTSTANDING = 8,
  parameter logic [3:0]  AWCACHE_VAL     = 4'b0011,
  localparam int         IDX_W           = $clog2(NUM_REQ),
  localparam int         LID_W           = ID_MAX_WIDTH - IDX_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*LID_W-1:0]      req_id,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*4-1:0]          req_len,
  input  logic [NUM_REQ*3-1:0]          req_size,
  input  logic [NUM_REQ*2-1:0]          req_burst,
  input  logic [NUM_REQ*3-1:0]          req_prot,
  input  logic [NUM_REQ*4-1:0]          req_qos,
  output logic                          m_awvalid,
  input  logic                          m_awready,
  output logic [ID_MAX_WIDTH-1:0]       m_awid,
  output logic [ADDR_WIDTH-1:0]         m_awaddr,
  output logic [3:0]                    m_awlen,
  output logic [2:0]                    m_awsize,
  output logic [1:0]                    m_awburst,
  output logic [1:0]                    m_awlock,
  output logic [3:0]                    m_awcache,
  output logic [2:0]                    m_awprot,
  output logic [3:0]                    m_awqos,
  input  logic                          b_valid,
  input  logic                          b_ready,
  input  logic [ID_MAX_WIDTH-1:0]       b_id,
  output logic [NUM_REQ*8-1:0]          outstanding,
  output logic                          err_underflow
);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  localparam logic [7:0] CNT_MAX = 8'(MAX_OUTSTANDING);

  state_t state;

  logic [LID_W-1:0]       id_a    [NUM_REQ];
  logic [ADDR_WIDTH-1:0]  addr_a  [NUM_REQ];
  logic [AXI_LEN_W-1:0]   len_a   [NUM_REQ];
  logic [AXI_SIZE_W-1:0]  size_a  [NUM_REQ];
  logic [AXI_BURST_W-1:0] burst_a [NUM_REQ];
  logic [AXI_PROT_W-1:0]  prot_a  [NUM_REQ];
  logic [AXI_QOS_W-1:0]   qos_a   [NUM_REQ];
  logic [7:0]             cnt     [NUM_REQ];

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] inc;
  logic [NUM_REQ-1:0] dec;
  logic [NUM_REQ-1:0] uf_hit;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   b_src;
  logic               any;
  logic               advance;
  logic               b_fire;
  logic               unused_bid_low;

  genvar r;
  generate
    for (r = 0; r < NUM_REQ; r++) begin : g_req
      assign id_a[r]    = req_id[r*LID_W +: LID_W];
      assign addr_a[r]  = req_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
      assign len_a[r]   = req_len[r*4 +: 4];
      assign size_a[r]  = req_size[r*3 +: 3];
      assign burst_a[r] = req_burst[r*2 +: 2];
      assign prot_a[r]  = req_prot[r*3 +: 3];
      assign qos_a[r]   = req_qos[r*4 +: 4];

      assign elig[r]   = req_valid[r] && (cnt[r] < CNT_MAX);
      assign inc[r]    = req_valid[r] && req_ready[r];
      assign dec[r]    = b_fire && (b_src == IDX_W'(r));
      assign uf_hit[r] = dec[r] && (cnt[r] == 8'd0);
      assign outstanding[r*8 +: 8] = cnt[r];

      // Simultaneous inc and dec cancel; a dec at zero is flagged, not applied.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt[r] <= 8'd0;
        end else if (inc[r] && !dec[r]) begin
          cnt[r] <= cnt[r] + 8'd1;
        end else if (dec[r] && !inc[r] && cnt[r] != 8'd0) begin
          cnt[r] <= cnt[r] - 8'd1;
        end
      end
    end
  endgenerate

  // Source indices >= NUM_REQ never match any dec[r] and are dropped.
  assign b_fire         = b_valid && b_ready;
  assign b_src          = b_id[ID_MAX_WIDTH-1 -: IDX_W];
  assign unused_bid_low = ^b_id[LID_W-1:0];

  // The output register can take a new request when empty, or when its
  // current content is leaving this cycle (back-to-back issue).
  assign advance   = !rst && any && ((state == S_IDLE) || m_awready);
  assign req_ready = {NUM_REQ{advance}} & grant;
  assign m_awlock  = AWLOCK_NORMAL;

  axi_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (elig),
    .advance   (advance),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      m_awvalid <= 1'b0;
      m_awid    <= '0;
      m_awaddr  <= '0;
      m_awlen   <= '0;
      m_awsize  <= '0;
      m_awburst <= '0;
      m_awcache <= '0;
      m_awprot  <= '0;
      m_awqos   <= '0;
    end else if (advance) begin
      state     <= S_HOLD;
      m_awvalid <= 1'b1;
      m_awid    <= {grant_idx, id_a[grant_idx]};
      m_awaddr  <= addr_a[grant_idx];
      m_awlen   <= len_a[grant_idx];
      m_awsize  <= size_a[grant_idx];
      m_awburst <= burst_a[grant_idx];
      m_awcache <= AWCACHE_VAL;
      m_awprot  <= prot_a[grant_idx];
      m_awqos   <= qos_a[grant_idx];
    end else if (state == S_HOLD && m_awready) begin
      state     <= S_IDLE;
      m_awvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_underflow <= 1'b0;
    end else if (|uf_hit) begin
      err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_aw_arbiter.sv
module tb_axi_aw_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [55:0]  req_id;
  logic [127:0] req_addr;
  logic [15:0]  req_len;
  logic [11:0]  req_size;
  logic [7:0]   req_burst;
  logic [11:0]  req_prot;
  logic [15:0]  req_qos;
  logic         m_awvalid;
  logic         m_awready;
  logic [15:0]  m_awid;
  logic [31:0]  m_awaddr;
  logic [3:0]   m_awlen;
  logic [2:0]   m_awsize;
  logic [1:0]   m_awburst;
  logic [1:0]   m_awlock;
  logic [3:0]   m_awcache;
  logic [2:0]   m_awprot;
  logic [3:0]   m_awqos;
  logic         b_valid;
  logic         b_ready;
  logic [15:0]  b_id;
  logic [31:0]  outstanding;
  logic         err_underflow;

  logic [13:0]  id_a   [4];
  logic [31:0]  addr_a [4];
  logic [3:0]   len_a  [4];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi_aw_arbiter #(
    .NUM_REQ(4), .ID_MAX_WIDTH(16), .ADDR_WIDTH(32),
    .MAX_OUTSTANDING(2), .AWCACHE_VAL(4'b0011)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_id(req_id), .req_addr(req_addr), .req_len(req_len),
    .req_size(req_size), .req_burst(req_burst), .req_prot(req_prot),
    .req_qos(req_qos),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache),
    .m_awprot(m_awprot), .m_awqos(m_awqos),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id),
    .outstanding(outstanding), .err_underflow(err_underflow)
  );

  always_comb begin
    req_id   = '0;
    req_addr = '0;
    req_len  = '0;
    for (int i = 0; i < 4; i++) begin
      req_id[i*14 +: 14]   = id_a[i];
      req_addr[i*32 +: 32] = addr_a[i];
      req_len[i*4 +: 4]    = len_a[i];
    end
  end

  assign req_size  = {4{3'd2}};
  assign req_burst = {4{2'b01}};
  assign req_prot  = {3'd3, 3'd2, 3'd1, 3'd0};
  assign req_qos   = 16'h3210;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 4'b0000;
    b_valid   = 1'b0;
    b_ready   = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic set_defaults();
    for (int i = 0; i < 4; i++) begin
      id_a[i]   = 14'(16'h10 + i);
      addr_a[i] = 32'h2000_0000 + 32'(i * 32'h100);
      len_a[i]  = 4'(i);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b0000;
    m_awready = 1'b0;
    b_valid   = 1'b0;
    b_ready   = 1'b0;
    b_id      = '0;
    set_defaults();
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_awvalid", m_awvalid, 1'b0);
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_outstanding", outstanding, 32'h0);
    chk("rst_err", err_underflow, 1'b0);
    chk("rst_awid", m_awid, 16'h0);

    // Single requester
    id_a[1] = 14'h5; addr_a[1] = 32'h1000; len_a[1] = 4'd3;
    req_valid = 4'b0010; m_awready = 1'b1;
    #1 chk("t1_ready", req_ready, 4'b0010);
    cyc();
    req_valid = 4'b0000;
    #1;
    chk("t1_awvalid", m_awvalid, 1'b1);
    chk("t1_awaddr", m_awaddr, 32'h1000);
    chk("t1_awid", m_awid, 16'h4005);
    chk("t1_awlen", m_awlen, 4'd3);
    chk("t1_awcache", m_awcache, 4'b0011);
    chk("t1_awlock", m_awlock, 2'b00);
    chk("t1_awprot", m_awprot, 3'd1);
    chk("t1_out1", outstanding[15:8], 8'd1);
    cyc();
    #1 chk("t1_idle", m_awvalid, 1'b0);
    b_valid = 1'b1; b_ready = 1'b1; b_id = 16'h4005;
    cyc();
    b_valid = 1'b0; b_ready = 1'b0;
    #1;
    chk("t1_out1_released", outstanding[15:8], 8'd0);
    chk("t1_err", err_underflow, 1'b0);

    // Continuous round robin, no bubble
    set_defaults();
    do_reset();
    req_valid = 4'b1111; m_awready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("t2_ready", req_ready, 64'(1) << (k % 4));
      if (k > 0) begin
        chk("t2_awvalid", m_awvalid, 1'b1);
        chk("t2_awid", m_awid, 64'((((k - 1) % 4) << 14) | (16'h10 + ((k - 1) % 4))));
      end
      cyc();
    end
    #1;
    chk("t2_ready_limit", req_ready, 4'b0000);
    chk("t2_awid_last", m_awid, 16'hC013);
    chk("t2_awqos_last", m_awqos, 4'd3);
    chk("t2_outstanding", outstanding, 32'h0202_0202);
    cyc();
    #1 chk("t2_drain", m_awvalid, 1'b0);

    // Backpressure
    do_reset();
    req_valid = 4'b1111; m_awready = 1'b0;
    #1 chk("t3_first_ready", req_ready, 4'b0001);
    cyc();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t3_hold_ready", req_ready, 4'b0000);
      chk("t3_hold_valid", m_awvalid, 1'b1);
      chk("t3_hold_awid", m_awid, 16'h0010);
      chk("t3_hold_awaddr", m_awaddr, 32'h2000_0000);
      cyc();
    end
    m_awready = 1'b1;
    #1 chk("t3_release_ready", req_ready, 4'b0010);
    cyc();
    req_valid = 4'b0000;
    #1;
    chk("t3_next_awid", m_awid, 16'h4011);
    chk("t3_next_awaddr", m_awaddr, 32'h2000_0100);
    cyc();

    // Outstanding limit of 2
    do_reset();
    m_awready = 1'b1;
    req_valid = 4'b0001;
    #1 chk("t4_c0", req_ready, 4'b0001);
    cyc();
    #1 chk("t4_c1", req_ready, 4'b0001);
    cyc();
    req_valid = 4'b1111;
    #1;
    chk("t4_out0_full", outstanding[7:0], 8'd2);
    chk("t4_skip0_a", req_ready, 4'b0010);
    cyc();
    #1 chk("t4_skip0_b", req_ready, 4'b0100);
    cyc();
    #1 chk("t4_skip0_c", req_ready, 4'b1000);
    cyc();
    #1 chk("t4_skip0_wrap", req_ready, 4'b0010);
    cyc();
    req_valid = 4'b0001;
    #1 chk("t4_blocked", req_ready, 4'b0000);
    cyc();
    b_valid = 1'b1; b_ready = 1'b1; b_id = 16'h0123;
    #1 chk("t4_blocked_bcycle", req_ready, 4'b0000);
    cyc();
    b_valid = 1'b0; b_ready = 1'b0;
    #1;
    chk("t4_out0_after_b", outstanding[7:0], 8'd1);
    chk("t4_reeligible", req_ready, 4'b0001);
    cyc();
    req_valid = 4'b0000;
    cyc();

    // Simultaneous inc/dec and underflow
    do_reset();
    m_awready = 1'b1;
    req_valid = 4'b0100;
    #1 chk("t5_c0", req_ready, 4'b0100);
    cyc();
    req_valid = 4'b0000;
    #1 chk("t5_out2_one", outstanding[23:16], 8'd1);
    cyc();
    req_valid = 4'b0100;
    b_valid = 1'b1; b_ready = 1'b1; b_id = 16'h8007;
    #1 chk("t5_c2_ready", req_ready, 4'b0100);
    cyc();
    req_valid = 4'b0000;
    b_id = 16'hC000;
    #1;
    chk("t5_out2_unchanged", outstanding[23:16], 8'd1);
    chk("t5_err_before", err_underflow, 1'b0);
    cyc();
    b_valid = 1'b0; b_ready = 1'b0;
    #1;
    chk("t5_err_set", err_underflow, 1'b1);
    chk("t5_out3_zero", outstanding[31:24], 8'd0);
    cyc();
    #1 chk("t5_err_sticky", err_underflow, 1'b1);

    // Reset while holding
    m_awready = 1'b0;
    req_valid = 4'b1111;
    #1 chk("t6_grant3", req_ready, 4'b1000);
    cyc();
    #1;
    chk("t6_holding", m_awvalid, 1'b1);
    chk("t6_out3", outstanding[31:24], 8'd1);
    rst = 1'b1;
    #1 chk("t6_ready_in_rst", req_ready, 4'b0000);
    cyc();
    rst = 1'b0;
    #1;
    chk("t6_awvalid_dropped", m_awvalid, 1'b0);
    chk("t6_counts_cleared", outstanding, 32'h0);
    chk("t6_err_cleared", err_underflow, 1'b0);
    chk("t6_req0_first", req_ready, 4'b0001);
    cyc();
    req_valid = 4'b0000;
    #1 chk("t6_awid", m_awid, 16'h0010);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
